// File: rtl/weight_load_sequencer.sv
// weight_load_sequencer
// Loads one weight tile from weight memory into the load/store array:
// programs the array's address counter and page register, strobes the
// counter enable for N words and drives the one-hot per-unit load strobes,
// delayed to line up with the registered address plus the memory read
// latency. Reports busy/done and supports abort.
// Optional build macro: WLS_PERF_CNT_EN adds load_cycles_o, the cycle count
// from accept to done of the last completed load.
// Precision codes: 0 = INT8, 1 = INT16, 2 = INT32, 3 = INT64; larger codes
// are unsupported.
module weight_load_sequencer #(
    parameter int ROWS                   = 4,
    parameter int COLUMNS                = 4,
    parameter int MEM_LATENCY            = 1,
    parameter int address_leng_wm        = 32,
    parameter int LOG_ALLOWED_PRECISIONS = 3
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              start_i,
    input  logic                              abort_i,
    input  logic [LOG_ALLOWED_PRECISIONS-1:0] data_precision_i,
    input  logic [address_leng_wm-1:0]        start_addr_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              prec_error_o,
    output logic                              enable_cnt_weight_o,
    output logic                              ld_max_cnt_weight_o,
    output logic [$clog2(ROWS*COLUMNS):0]     max_cnt_weight_o,
    output logic                              ld_weight_page_cnt_o,
    output logic [address_leng_wm-1:0]        start_value_wm_o,
    output logic [ROWS*COLUMNS-1:0]           read_weight_memory_o
`ifdef WLS_PERF_CNT_EN
    ,
    output logic [15:0]                       load_cycles_o
`endif
);

    localparam int UNITS = ROWS * COLUMNS;
    localparam int CNT_W = $clog2(UNITS) + 1;
    localparam int DEPTH = 1 + MEM_LATENCY;

    localparam logic [LOG_ALLOWED_PRECISIONS-1:0] PREC_INT64 = LOG_ALLOWED_PRECISIONS'(3);
    localparam logic [CNT_W-1:0]                  CNT_ONE    = CNT_W'(1);
    localparam logic [UNITS-1:0]                  UNIT_ONE   = UNITS'(1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic                       busy_q, done_q, precErr_q, enable_q, ldMax_q, ldPage_q;
    logic [CNT_W-1:0]           maxCnt_q;
    logic [address_leng_wm-1:0] startValue_q;
    logic [CNT_W-1:0]           ac_q, issueCnt_q, row_q, col_q;
    logic [UNITS-1:0]           pipe_q [DEPTH];

    logic                       accept, precBad, lastIssue, inFlight, flush;
    logic [CNT_W-1:0]           acNew, nNew;
    logic [UNITS-1:0]           issueVec;
    int                         unitIdx;

    // Active columns per precision: COLUMNS shifted down by 3..0, never below one.
    function automatic logic [CNT_W-1:0] activeCols(input logic [LOG_ALLOWED_PRECISIONS-1:0] code);
        int ac;
        if (code > PREC_INT64) begin
            ac = 1;
        end else begin
            ac = COLUMNS >> (3 - int'(code));
            if (ac < 1) ac = 1;
        end
        return CNT_W'(ac);
    endfunction

    assign acNew     = activeCols(data_precision_i);
    assign nNew      = CNT_W'(ROWS * int'(acNew));
    assign lastIssue = (issueCnt_q == (maxCnt_q - CNT_ONE));
    assign flush     = abort_i && (state_q != IDLE);

    // Next-state logic; abort from any busy state overrides the normal flow.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        precBad = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (data_precision_i <= PREC_INT64) begin
                        state_d = SETUP;
                        accept  = 1'b1;
                    end else begin
                        precBad = 1'b1;
                    end
                end
            end
            SETUP:   state_d = ISSUE;
            ISSUE:   if (lastIssue) state_d = DRAIN;
            DRAIN:   if (!inFlight) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Words still travelling toward the output stage of the delay line.
    always_comb begin
        inFlight = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            inFlight = inFlight | (|pipe_q[k]);
        end
    end

    // One-hot strobe for the word being issued this cycle (row-major unit index).
    always_comb begin
        unitIdx  = int'(row_q) * COLUMNS + int'(col_q);
        issueVec = '0;
        if (state_q == ISSUE && unitIdx < UNITS) begin
            issueVec = UNIT_ONE << unitIdx;
        end
    end

    // State, registered control outputs and the issue counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            precErr_q    <= 1'b0;
            enable_q     <= 1'b0;
            ldMax_q      <= 1'b0;
            ldPage_q     <= 1'b0;
            maxCnt_q     <= '0;
            startValue_q <= '0;
            ac_q         <= '0;
            issueCnt_q   <= '0;
            row_q        <= '0;
            col_q        <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= (state_d == SETUP) || (state_d == ISSUE) || (state_d == DRAIN);
            done_q    <= (state_d == DONE);
            ldMax_q   <= (state_d == SETUP);
            ldPage_q  <= (state_d == SETUP);
            enable_q  <= (state_d == ISSUE);
            precErr_q <= precBad;
            if (accept) begin
                maxCnt_q     <= nNew;
                startValue_q <= start_addr_i;
                ac_q         <= acNew;
                issueCnt_q   <= '0;
                row_q        <= '0;
                col_q        <= '0;
            end else if (state_q == ISSUE) begin
                issueCnt_q <= issueCnt_q + CNT_ONE;
                if (col_q == (ac_q - CNT_ONE)) begin
                    col_q <= '0;
                    row_q <= row_q + CNT_ONE;
                end else begin
                    col_q <= col_q + CNT_ONE;
                end
            end
        end
    end

    // Delay line aligning strobes with the registered address and memory latency.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            pipe_q[0] <= issueVec;
            for (int k = 1; k < DEPTH; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    assign busy_o               = busy_q;
    assign done_o               = done_q;
    assign prec_error_o         = precErr_q;
    assign enable_cnt_weight_o  = enable_q;
    assign ld_max_cnt_weight_o  = ldMax_q;
    assign ld_weight_page_cnt_o = ldPage_q;
    assign max_cnt_weight_o     = maxCnt_q;
    assign start_value_wm_o     = startValue_q;
    assign read_weight_memory_o = pipe_q[DEPTH-1];

`ifdef WLS_PERF_CNT_EN
    logic [15:0] cycleCnt_q, loadCycles_q;

    // Saturating accept-to-done cycle counter, captured only when a load completes.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cycleCnt_q   <= '0;
            loadCycles_q <= '0;
        end else begin
            if (accept) begin
                cycleCnt_q <= 16'd1;
            end else if (state_q != IDLE && cycleCnt_q != 16'hFFFF) begin
                cycleCnt_q <= cycleCnt_q + 16'd1;
            end
            if (state_d == DONE) begin
                loadCycles_q <= (cycleCnt_q == 16'hFFFF) ? 16'hFFFF : cycleCnt_q + 16'd1;
            end
        end
    end

    assign load_cycles_o = loadCycles_q;
`endif

endmodule

// File: tb/tb_weight_load_sequencer.sv
// tb_weight_load_sequencer
// Directed scenarios followed by random start/abort/reset traffic, checked
// every cycle against a transaction-level model of the sequencer timeline.
module tb_weight_load_sequencer;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int ML    = 1;
    localparam int AW    = 32;
    localparam int PW    = 3;
    localparam int UNITS = ROWS * COLS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         reset, start, abort;
    logic [PW-1:0]                prec;
    logic [AW-1:0]                addr;
    logic                         busy, done, precErr, enCnt, ldMax, ldPage;
    logic [$clog2(UNITS):0]       maxCnt;
    logic [AW-1:0]                startValue;
    logic [UNITS-1:0]             readMem;
`ifdef WLS_PERF_CNT_EN
    logic [15:0]                  loadCycles;
`endif

    weight_load_sequencer #(
        .ROWS(ROWS), .COLUMNS(COLS), .MEM_LATENCY(ML),
        .address_leng_wm(AW), .LOG_ALLOWED_PRECISIONS(PW)
    ) dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .start_i             (start),
        .abort_i             (abort),
        .data_precision_i    (prec),
        .start_addr_i        (addr),
        .busy_o              (busy),
        .done_o              (done),
        .prec_error_o        (precErr),
        .enable_cnt_weight_o (enCnt),
        .ld_max_cnt_weight_o (ldMax),
        .max_cnt_weight_o    (maxCnt),
        .ld_weight_page_cnt_o(ldPage),
        .start_value_wm_o    (startValue),
        .read_weight_memory_o(readMem)
`ifdef WLS_PERF_CNT_EN
        ,
        .load_cycles_o       (loadCycles)
`endif
    );

    int checkCount = 0;
    int passCount  = 0;

    // Model: a load is a timeline of k = 1..L cycles after the accept cycle.
    bit          mActive   = 1'b0;
    int          mK        = 0;
    int          mN        = 0;
    int          mAC       = 1;
    int          mL        = 0;
    int          mMax      = 0;
    logic [AW-1:0] mAddr   = '0;
    bit          mPrecErr  = 1'b0;
    int          mLastLoad = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, actual, expected);
        end
    endtask

    function automatic int unitOf(input int i, input int ac);
        return (i / ac) * COLS + (i % ac);
    endfunction

    task automatic compareCycle();
        bit          eBusy, eDone, eLd, eEn;
        int          i;
        logic [31:0] eRead;
        eBusy = mActive && (mK < mL);
        eDone = mActive && (mK == mL);
        eLd   = mActive && (mK == 1);
        eEn   = mActive && (mK >= 2) && (mK <= mN + 1);
        i     = mK - 3 - ML;
        eRead = '0;
        if (mActive && i >= 0 && i < mN) eRead = 32'd1 << unitOf(i, mAC);
        checkOutput("busy",       32'(busy),       32'(eBusy));
        checkOutput("done",       32'(done),       32'(eDone));
        checkOutput("prec_error", 32'(precErr),    32'(mPrecErr));
        checkOutput("enable_cnt", 32'(enCnt),      32'(eEn));
        checkOutput("ld_max_cnt", 32'(ldMax),      32'(eLd));
        checkOutput("ld_page",    32'(ldPage),     32'(eLd));
        checkOutput("max_cnt",    32'(maxCnt),     32'(mMax));
        checkOutput("start_val",  32'(startValue), 32'(mAddr));
        checkOutput("read_wm",    32'(readMem),    eRead);
`ifdef WLS_PERF_CNT_EN
        checkOutput("load_cycles", 32'(loadCycles), 32'(mLastLoad));
`endif
    endtask

    task automatic modelStep(input bit rst, input bit st, input bit ab,
                             input logic [PW-1:0] p, input logic [AW-1:0] a);
        if (rst) begin
            mActive = 0; mK = 0; mMax = 0; mAddr = '0; mPrecErr = 0; mLastLoad = 0;
            return;
        end
        mPrecErr = 0;
        if (mActive) begin
            if (ab || mK == mL) begin
                mActive = 0;
            end else begin
                mK++;
                if (mK == mL) mLastLoad = mL;
            end
        end else if (st) begin
            if (p <= 3) begin
                mAC = COLS >> (3 - int'(p));
                if (mAC < 1) mAC = 1;
                mN      = ROWS * mAC;
                mL      = 1 + mN + 1 + ML + 1;
                mActive = 1;
                mK      = 1;
                mMax    = mN;
                mAddr   = a;
            end else begin
                mPrecErr = 1;
            end
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit st, input bit ab,
                                 input logic [PW-1:0] p, input logic [AW-1:0] a);
        reset = rst; start = st; abort = ab; prec = p; addr = a;
        @(negedge clk);
        compareCycle();
        modelStep(rst, st, ab, p, a);
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int c = 0; c < n; c++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; prec = '0; addr = '0;
        repeat (2) @(posedge clk);
        #1;

        idleCycles(3);

        // INT64 full tile
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd3, 32'h20);
        idleCycles(22);

        // INT32 half tile
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd2, 32'h140);
        idleCycles(14);

        // INT8: active columns floored to one
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 32'h300);
        idleCycles(12);

        // Abort on the third ISSUE cycle, then a fresh load
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd3, 32'h400);
        idleCycles(3);
        applyStimulus(1'b0, 1'b0, 1'b1, '0, '0);
        idleCycles(5);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd1, 32'h500);
        idleCycles(12);

        // Unsupported precision, then a start ignored while busy
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd5, 32'h600);
        idleCycles(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd2, 32'h700);
        idleCycles(3);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 32'h800);
        idleCycles(14);

        // Reset in the middle of a load
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd3, 32'h900);
        idleCycles(6);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        idleCycles(3);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            bit            rRst, rSt, rAb;
            logic [PW-1:0] rP;
            logic [AW-1:0] rA;
            rRst = ($urandom_range(0, 499) == 0);
            rSt  = ($urandom_range(0, 5) == 0);
            rAb  = ($urandom_range(0, 59) == 0);
            rP   = ($urandom_range(0, 9) == 0) ? PW'($urandom_range(4, 7)) : PW'($urandom_range(0, 3));
            rA   = $urandom & 32'hFFFF_FF00;
            applyStimulus(rRst, rSt, rAb, rP, rA);
        end
        idleCycles(30);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
